// File: rtl/biriscv_exec_pipe.sv
// RV32I integer execute pipeline: a single-cycle ALU feeding a STAGES-deep
// result pipeline, with registered and same-cycle branch resolution.
module biriscv_exec_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned STAGES    = 2,
  parameter bit          BRANCH_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            opcode_valid_i,
  input  logic [31:0]     opcode_opcode_i,
  input  logic [XLEN-1:0] opcode_pc_i,
  input  logic [4:0]      opcode_rd_idx_i,
  input  logic [4:0]      opcode_ra_idx_i,
  input  logic [XLEN-1:0] opcode_ra_operand_i,
  input  logic [XLEN-1:0] opcode_rb_operand_i,
  input  logic            hold_i,
  input  logic            flush_i,
  output logic            writeback_valid_o,
  output logic [4:0]      writeback_rd_idx_o,
  output logic [XLEN-1:0] writeback_value_o,
  output logic [31:0]     stage_rd_mask_o,
  output logic            branch_request_o,
  output logic            branch_is_taken_o,
  output logic            branch_is_not_taken_o,
  output logic            branch_is_call_o,
  output logic            branch_is_ret_o,
  output logic            branch_is_jmp_o,
  output logic [XLEN-1:0] branch_source_o,
  output logic [XLEN-1:0] branch_pc_o,
  output logic            branch_d_request_o,
  output logic [XLEN-1:0] branch_d_pc_o
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("biriscv_exec_pipe: XLEN must be 32");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("biriscv_exec_pipe: STAGES must be in 1..4");
  end

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [6:0]      opc;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] result;

  assign opc      = opcode_opcode_i[6:0];
  assign funct3   = opcode_opcode_i[14:12];
  assign funct7   = opcode_opcode_i[31:25];
  assign imm_i    = {{(XLEN-12){opcode_opcode_i[31]}}, opcode_opcode_i[31:20]};
  assign imm_u    = {opcode_opcode_i[31:12], 12'b0};
  assign pc_plus4 = opcode_pc_i + XLEN'(4);

  // alt selects SUB over ADD and SRA over SRL.
  function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic alt,
                                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    sa = a;
    case (f3)
      3'b000:  return alt ? a - b : a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b011:  return {{(XLEN-1){1'b0}}, (a < b)};
      3'b100:  return a ^ b;
      3'b101:  return alt ? XLEN'(sa >>> b[4:0]) : a >> b[4:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  // NOTE: every variable assigned in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    result = '0;
    case (opc)
      OPC_OP: begin
        if (funct7 == 7'h00 ||
            (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))
          result = alu(funct3, funct7[5], opcode_ra_operand_i, opcode_rb_operand_i);
      end
      OPC_OPIMM: begin
        if ((funct3 != 3'b001 && funct3 != 3'b101) || funct7 == 7'h00 ||
            (funct3 == 3'b101 && funct7 == 7'h20))
          result = alu(funct3, (funct3 == 3'b101) && funct7[5], opcode_ra_operand_i, imm_i);
      end
      OPC_LUI:   result = imm_u;
      OPC_AUIPC: result = opcode_pc_i + imm_u;
      OPC_JAL:   result = pc_plus4;
      OPC_JALR:  if (funct3 == 3'b000) result = pc_plus4;
      default:   result = '0;
    endcase
  end

  // Result pipeline: index 0 is stage 1, index STAGES-1 drives writeback.
  logic [STAGES-1:0] stage_valid_q;
  logic [4:0]        stage_rd_q    [STAGES];
  logic [XLEN-1:0]   stage_value_q [STAGES];

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its predecessor's pre-edge value; blocking here would collapse the shift.
  // NOTE: these register arrays are pipeline flops rather than a RAM, so they
  // are reset in full -- the outputs they drive must read 0 during reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_valid_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        stage_rd_q[s]    <= '0;
        stage_value_q[s] <= '0;
      end
    end else if (flush_i) begin
      stage_valid_q <= '0;
    end else if (!hold_i) begin
      stage_valid_q[0] <= opcode_valid_i;
      stage_rd_q[0]    <= opcode_rd_idx_i;
      stage_value_q[0] <= (opcode_rd_idx_i == 5'd0) ? '0 : result;
      for (int s = 1; s < STAGES; s++) begin
        stage_valid_q[s] <= stage_valid_q[s-1];
        stage_rd_q[s]    <= stage_rd_q[s-1];
        stage_value_q[s] <= stage_value_q[s-1];
      end
    end
  end

  assign writeback_valid_o  = stage_valid_q[STAGES-1];
  assign writeback_rd_idx_o = stage_rd_q[STAGES-1];
  assign writeback_value_o  = stage_value_q[STAGES-1];

  // x0 results never create a hazard, so they stay out of the mask.
  always_comb begin
    stage_rd_mask_o = '0;
    for (int s = 0; s < STAGES; s++) begin
      if (stage_valid_q[s] && stage_rd_q[s] != 5'd0)
        stage_rd_mask_o[stage_rd_q[s]] = 1'b1;
    end
  end

  if (BRANCH_EN) begin : g_branch
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] jalr_sum;
    logic            br_is;
    logic            br_taken;
    logic            br_call;
    logic            br_ret;
    logic            br_jmp;
    logic [XLEN-1:0] br_target;

    logic            request_q;
    logic            taken_q;
    logic            not_taken_q;
    logic            call_q;
    logic            ret_q;
    logic            jmp_q;
    logic [XLEN-1:0] source_q;
    logic [XLEN-1:0] pc_q;

    assign imm_b = {{(XLEN-12){opcode_opcode_i[31]}}, opcode_opcode_i[7],
                    opcode_opcode_i[30:25], opcode_opcode_i[11:8], 1'b0};
    assign imm_j = {{(XLEN-20){opcode_opcode_i[31]}}, opcode_opcode_i[19:12],
                    opcode_opcode_i[20], opcode_opcode_i[30:21], 1'b0};
    assign jalr_sum = opcode_ra_operand_i + imm_i;

    always_comb begin
      br_is     = 1'b0;
      br_taken  = 1'b0;
      br_call   = 1'b0;
      br_ret    = 1'b0;
      br_jmp    = 1'b0;
      br_target = '0;
      case (opc)
        OPC_JAL: begin
          br_is     = 1'b1;
          br_taken  = 1'b1;
          br_target = opcode_pc_i + imm_j;
          br_call   = (opcode_rd_idx_i == 5'd1);
          br_jmp    = ~br_call;
        end
        OPC_JALR: begin
          if (funct3 == 3'b000) begin
            br_is     = 1'b1;
            br_taken  = 1'b1;
            br_target = {jalr_sum[XLEN-1:1], 1'b0};
            br_ret    = (opcode_ra_idx_i == 5'd1) && (imm_i == '0);
            br_call   = ~br_ret && (opcode_rd_idx_i == 5'd1);
            br_jmp    = ~br_call && ~br_ret;
          end
        end
        OPC_BRANCH: begin
          br_is     = 1'b1;
          br_target = opcode_pc_i + imm_b;
          case (funct3)
            3'b000:  br_taken = (opcode_ra_operand_i == opcode_rb_operand_i);
            3'b001:  br_taken = (opcode_ra_operand_i != opcode_rb_operand_i);
            3'b100:  br_taken = ($signed(opcode_ra_operand_i) <  $signed(opcode_rb_operand_i));
            3'b101:  br_taken = ($signed(opcode_ra_operand_i) >= $signed(opcode_rb_operand_i));
            3'b110:  br_taken = (opcode_ra_operand_i <  opcode_rb_operand_i);
            3'b111:  br_taken = (opcode_ra_operand_i >= opcode_rb_operand_i);
            default: br_is    = 1'b0;
          endcase
        end
        default: br_is = 1'b0;
      endcase
    end

    // Flush clears even under hold; an idle unheld cycle also clears.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i || flush_i || (!hold_i && !(opcode_valid_i && br_is))) begin
        request_q   <= 1'b0;
        taken_q     <= 1'b0;
        not_taken_q <= 1'b0;
        call_q      <= 1'b0;
        ret_q       <= 1'b0;
        jmp_q       <= 1'b0;
        source_q    <= '0;
        pc_q        <= '0;
      end else if (!hold_i) begin
        request_q   <= 1'b1;
        taken_q     <= br_taken;
        not_taken_q <= ~br_taken;
        call_q      <= br_call;
        ret_q       <= br_ret;
        jmp_q       <= br_jmp;
        source_q    <= opcode_pc_i;
        pc_q        <= br_taken ? br_target : pc_plus4;
      end
    end

    assign branch_request_o      = request_q;
    assign branch_is_taken_o     = taken_q;
    assign branch_is_not_taken_o = not_taken_q;
    assign branch_is_call_o      = call_q;
    assign branch_is_ret_o       = ret_q;
    assign branch_is_jmp_o       = jmp_q;
    assign branch_source_o       = source_q;
    assign branch_pc_o           = pc_q;
    assign branch_d_request_o    = opcode_valid_i & br_is & br_taken & ~flush_i;
    assign branch_d_pc_o         = br_target;
  end else begin : g_no_branch
    assign branch_request_o      = 1'b0;
    assign branch_is_taken_o     = 1'b0;
    assign branch_is_not_taken_o = 1'b0;
    assign branch_is_call_o      = 1'b0;
    assign branch_is_ret_o       = 1'b0;
    assign branch_is_jmp_o       = 1'b0;
    assign branch_source_o       = '0;
    assign branch_pc_o           = '0;
    assign branch_d_request_o    = 1'b0;
    assign branch_d_pc_o         = '0;
  end

endmodule

// File: tb/tb_biriscv_exec_pipe.sv
// Self-checking bench for biriscv_exec_pipe: directed scenarios plus random
// traffic compared against an age-queue reference model.
module tb_biriscv_exec_pipe;

  localparam int STAGES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] ins = '0;
  logic [31:0] pc = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  ra_idx = '0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;

  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_value;
  logic [31:0] rd_mask;
  logic        br_req, br_taken, br_ntaken, br_call, br_ret, br_jmp;
  logic [31:0] br_src, br_pc;
  logic        br_d_req;
  logic [31:0] br_d_pc;

  biriscv_exec_pipe #(.XLEN(32), .STAGES(STAGES), .BRANCH_EN(1'b1)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .opcode_valid_i       (valid),
    .opcode_opcode_i      (ins),
    .opcode_pc_i          (pc),
    .opcode_rd_idx_i      (rd),
    .opcode_ra_idx_i      (ra_idx),
    .opcode_ra_operand_i  (opa),
    .opcode_rb_operand_i  (opb),
    .hold_i               (hold),
    .flush_i              (flush),
    .writeback_valid_o    (wb_valid),
    .writeback_rd_idx_o   (wb_rd),
    .writeback_value_o    (wb_value),
    .stage_rd_mask_o      (rd_mask),
    .branch_request_o     (br_req),
    .branch_is_taken_o    (br_taken),
    .branch_is_not_taken_o(br_ntaken),
    .branch_is_call_o     (br_call),
    .branch_is_ret_o      (br_ret),
    .branch_is_jmp_o      (br_jmp),
    .branch_source_o      (br_src),
    .branch_pc_o          (br_pc),
    .branch_d_request_o   (br_d_req),
    .branch_d_pc_o        (br_d_pc)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {R_NONE, R_ADD, R_SUB, R_SLL, R_SLT, R_SLTU, R_XOR, R_SRL, R_SRA,
                R_OR, R_AND, R_LUI, R_AUIPC, R_LINK} rop_e;

  typedef struct { logic [4:0] rd; logic [31:0] value; int age; } ent_t;
  typedef struct packed { logic is_br, taken, call, ret, jmp; logic [31:0] target; } binfo_t;
  typedef struct packed { logic req, taken, ntaken, call, ret, jmp; logic [31:0] src, pc; } breg_t;

  ent_t  inflight[$];
  breg_t exp_br = '0;

  function automatic logic [31:0] ref_result(input logic [31:0] w, input logic [31:0] p,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [6:0]  f7 = w[31:25];
    logic [31:0] imm = {{20{w[31]}}, w[31:20]};
    bit          is_imm = (w[6:0] == 7'h13);
    logic [31:0] src2 = is_imm ? imm : b;
    bit          plain = is_imm || f7 == 7'h00;
    rop_e        op = R_NONE;
    int          sa = a;
    if (w[6:0] == 7'h33 || is_imm) begin
      case (w[14:12])
        3'd0: op = (!is_imm && f7 == 7'h20) ? R_SUB : (plain ? R_ADD : R_NONE);
        3'd1: op = (f7 == 7'h00) ? R_SLL : R_NONE;
        3'd2: op = plain ? R_SLT : R_NONE;
        3'd3: op = plain ? R_SLTU : R_NONE;
        3'd4: op = plain ? R_XOR : R_NONE;
        3'd5: op = (f7 == 7'h00) ? R_SRL : ((f7 == 7'h20) ? R_SRA : R_NONE);
        3'd6: op = plain ? R_OR : R_NONE;
        default: op = plain ? R_AND : R_NONE;
      endcase
    end else if (w[6:0] == 7'h37) op = R_LUI;
    else if (w[6:0] == 7'h17) op = R_AUIPC;
    else if (w[6:0] == 7'h6f) op = R_LINK;
    else if (w[6:0] == 7'h67 && w[14:12] == 3'd0) op = R_LINK;
    case (op)
      R_ADD:   return a + src2;
      R_SUB:   return a - src2;
      R_SLL:   return a << src2[4:0];
      R_SLT:   return (int'(a) < int'(src2)) ? 32'd1 : 32'd0;
      R_SLTU:  return (a < src2) ? 32'd1 : 32'd0;
      R_XOR:   return a ^ src2;
      R_SRL:   return a >> src2[4:0];
      R_SRA:   return sa >>> src2[4:0];
      R_OR:    return a | src2;
      R_AND:   return a & src2;
      R_LUI:   return {w[31:12], 12'h000};
      R_AUIPC: return p + {w[31:12], 12'h000};
      R_LINK:  return p + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  function automatic binfo_t ref_branch(input logic [31:0] w, input logic [31:0] p,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] d, input logic [4:0] s);
    binfo_t      r = '0;
    logic [31:0] ii = {{20{w[31]}}, w[31:20]};
    logic [31:0] bi = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    logic [31:0] ji = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    if (w[6:0] == 7'h6f) begin
      r.is_br = 1; r.taken = 1; r.target = p + ji;
      r.call = (d == 5'd1); r.jmp = !r.call;
    end else if (w[6:0] == 7'h67 && w[14:12] == 3'd0) begin
      r.is_br = 1; r.taken = 1; r.target = (a + ii) & 32'hFFFF_FFFE;
      r.ret = (s == 5'd1) && (ii == 32'd0);
      r.call = !r.ret && (d == 5'd1);
      r.jmp = !r.call && !r.ret;
    end else if (w[6:0] == 7'h63) begin
      r.is_br = 1; r.target = p + bi;
      case (w[14:12])
        3'd0: r.taken = (a == b);
        3'd1: r.taken = (a != b);
        3'd4: r.taken = (int'(a) < int'(b));
        3'd5: r.taken = (int'(a) >= int'(b));
        3'd6: r.taken = (a < b);
        3'd7: r.taken = (a >= b);
        default: r.is_br = 0;
      endcase
    end
    return r;
  endfunction

  // Called at each rising edge with the inputs that edge samples.
  task automatic update_model();
    ent_t   nq[$];
    binfo_t bi;
    if (flush) begin
      inflight.delete();
      exp_br = '0;
      return;
    end
    if (hold) return;
    foreach (inflight[i]) begin
      if (inflight[i].age < STAGES) begin
        ent_t e = inflight[i];
        e.age++;
        nq.push_back(e);
      end
    end
    if (valid) nq.push_back('{rd, (rd == 5'd0) ? 32'd0 : ref_result(ins, pc, opa, opb), 1});
    inflight = nq;
    bi = ref_branch(ins, pc, opa, opb, rd, ra_idx);
    if (valid && bi.is_br)
      exp_br = '{1'b1, bi.taken, !bi.taken, bi.call, bi.ret, bi.jmp, pc,
                 bi.taken ? bi.target : pc + 32'd4};
    else
      exp_br = '0;
  endtask

  task automatic compare_outputs();
    logic        ev = 1'b0;
    logic [4:0]  erd = '0;
    logic [31:0] eval = '0;
    logic [31:0] emask = '0;
    binfo_t      bi = ref_branch(ins, pc, opa, opb, rd, ra_idx);
    logic        edreq = valid && bi.is_br && bi.taken && !flush;
    foreach (inflight[i]) begin
      if (inflight[i].rd != 5'd0) emask[inflight[i].rd] = 1'b1;
      if (inflight[i].age == STAGES) begin
        ev = 1'b1; erd = inflight[i].rd; eval = inflight[i].value;
      end
    end
    check("wb_valid", {31'b0, wb_valid}, {31'b0, ev});
    if (ev) begin
      check("wb_rd", {27'b0, wb_rd}, {27'b0, erd});
      check("wb_value", wb_value, eval);
    end
    check("rd_mask", rd_mask, emask);
    check("br_flags", {26'b0, br_req, br_taken, br_ntaken, br_call, br_ret, br_jmp},
          {26'b0, exp_br.req, exp_br.taken, exp_br.ntaken, exp_br.call, exp_br.ret, exp_br.jmp});
    check("br_src", br_src, exp_br.src);
    check("br_pc", br_pc, exp_br.pc);
    check("br_d_req", {31'b0, br_d_req}, {31'b0, edreq});
    if (edreq) check("br_d_pc", br_d_pc, bi.target);
  endtask

  // Check mid-cycle, advance one edge, return just after it.
  task automatic step();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic set_idle();
    valid = 0; ins = '0; pc = '0; rd = '0; ra_idx = '0; opa = '0; opb = '0;
    hold = 0; flush = 0;
  endtask

  task automatic issue(input logic [31:0] w, input logic [31:0] p, input logic [4:0] d,
                       input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
    valid = 1; ins = w; pc = p; rd = d; ra_idx = s; opa = a; opb = b;
    hold = 0; flush = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wb"}, {wb_valid, wb_rd, 26'b0}, 32'd0);
    check({tag, "_wb_value"}, wb_value, 32'd0);
    check({tag, "_mask"}, rd_mask, 32'd0);
    check({tag, "_br_flags"}, {26'b0, br_req, br_taken, br_ntaken, br_call, br_ret, br_jmp}, 32'd0);
    check({tag, "_br_src"}, br_src, 32'd0);
    check({tag, "_br_pc"}, br_pc, 32'd0);
    check({tag, "_br_d_req"}, {31'b0, br_d_req}, 32'd0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    set_idle();
    rst = 1;
    #1;
    check_zero(tag);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    inflight.delete();
    exp_br = '0;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] d);
    return {f7, 5'd2, 5'd1, f3, d, 7'h33};
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 9))
      0, 1: begin
        w[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0, 1: w[31:25] = 7'h00;
          2: w[31:25] = 7'h20;
          default: ;
        endcase
      end
      2, 3: begin
        w[6:0] = 7'h13;
        if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      4: w[6:0] = 7'h37;
      5: w[6:0] = 7'h17;
      6: w[6:0] = 7'h6f;
      7: begin
        w[6:0] = 7'h67;
        if ($urandom_range(0, 3) != 0) w[14:12] = 3'd0;
        if ($urandom_range(0, 1) == 1) w[31:20] = 12'd0;
      end
      8: w[6:0] = 7'h63;
      default: ;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    #2;
    do_reset("reset");

    // ADDI x5, x0, -1: writeback two edges after issue, x5 visible in mask meanwhile
    issue(32'hFFF0_0293, 32'h0, 5'd5, 5'd0, 32'h0, 32'h0);
    step();
    set_idle();
    check("addi_mask_c1", {31'b0, rd_mask[5]}, 32'd1);
    check("addi_wb_c1", {31'b0, wb_valid}, 32'd0);
    step();
    check("addi_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("addi_wb_rd", {27'b0, wb_rd}, 32'd5);
    check("addi_wb_value", wb_value, 32'hFFFF_FFFF);
    check("addi_mask_c2", {31'b0, rd_mask[5]}, 32'd1);
    step();

    // SRA uses only rb[4:0]
    issue(enc_r(7'h20, 3'b101, 5'd6), 32'h10, 5'd6, 5'd1, 32'h8000_0000, 32'h0000_0024);
    step();
    set_idle();
    step();
    check("sra_value", wb_value, 32'hF800_0000);
    step();

    // ADD then three held cycles: writeback arrives three edges late
    issue(enc_r(7'h00, 3'b000, 5'd7), 32'h20, 5'd7, 5'd1, 32'd100, 32'd23);
    step();
    n = 1;
    issue(enc_r(7'h00, 3'b000, 5'd9), 32'h24, 5'd9, 5'd1, 32'd1, 32'd1);
    hold = 1;
    repeat (3) begin step(); n++; end
    set_idle();
    while (!wb_valid && n < 10) begin step(); n++; end
    check("hold_latency", n, 32'd5);
    check("hold_value", wb_value, 32'd123);
    step();

    // two ops, then flush under hold: nothing survives
    issue(enc_r(7'h00, 3'b110, 5'd3), 32'h30, 5'd3, 5'd1, 32'hF0, 32'h0F);
    step();
    issue(enc_r(7'h00, 3'b111, 5'd4), 32'h34, 5'd4, 5'd1, 32'hF0, 32'h3C);
    step();
    issue(enc_r(7'h00, 3'b100, 5'd8), 32'h38, 5'd8, 5'd1, 32'h1, 32'h2);
    hold = 1;
    flush = 1;
    step();
    set_idle();
    check("flush_wb", {31'b0, wb_valid}, 32'd0);
    check("flush_mask", rd_mask, 32'd0);
    step();
    check("flush_wb_late", {31'b0, wb_valid}, 32'd0);

    // BEQ at 0x100, offset +0x20, equal operands
    issue({1'b0, 6'b000001, 5'd2, 5'd1, 3'b000, 4'b0000, 1'b0, 7'h63},
          32'h100, 5'd0, 5'd1, 32'd7, 32'd7);
    #1;
    check("beq_d_req", {31'b0, br_d_req}, 32'd1);
    check("beq_d_pc", br_d_pc, 32'h120);
    step();
    set_idle();
    check("beq_taken", {31'b0, br_taken}, 32'd1);
    check("beq_pc", br_pc, 32'h120);
    check("beq_src", br_src, 32'h100);
    step();

    // JALR x0, 0(x1) is a return; then reset mid-flight clears everything
    issue({12'h000, 5'd1, 3'b000, 5'd0, 7'h67}, 32'h200, 5'd0, 5'd1, 32'h2003, 32'h0);
    step();
    check("jalr_ret", {31'b0, br_ret}, 32'd1);
    check("jalr_pc", br_pc, 32'h2002);
    do_reset("midrst");

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd_rst");
      end else begin
        valid  = ($urandom_range(0, 9) < 7);
        ins    = rand_ins();
        pc     = {$urandom_range(0, 32'hFFFF), 2'b00};
        rd     = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 1)) : 5'($urandom);
        ra_idx = ($urandom_range(0, 3) == 0) ? 5'd1 : 5'($urandom);
        opa    = rand_operand();
        opb    = ($urandom_range(0, 3) == 0) ? opa : rand_operand();
        hold   = ($urandom_range(0, 4) == 0);
        flush  = ($urandom_range(0, 19) == 0);
        step();
      end
    end
    set_idle();
    repeat (STAGES + 1) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
